// File: rtl/clint_timer_if.sv
// Word-bus bundle between a software initiator and the core-local interruptor.
// The slave answers each accepted request with a one-cycle ack carrying rdata/err.
interface clint_timer_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ack, input err);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output rdata, output ack, output err);
endinterface

// File: rtl/clint_timer.sv
// Machine-level core-local interruptor: prescaled 64-bit mtime, mtimecmp, msip,
// and registered timer/software interrupt-pending levels for the CSR block.
module clint_timer #(
    parameter int unsigned PRESCALE   = 1,
    parameter bit          BASE_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    clint_timer_if.slave       bus,
    input  logic               halt_i,
    output logic               xtip_o,
    output logic               xsip_o,
    output logic [63:0]        mtime_o
);

    localparam int unsigned PRESCALE_EFF = (PRESCALE == 0) ? 1 : PRESCALE;
    localparam logic [15:0] PRE_MAX      = 16'(PRESCALE_EFF - 1);

    localparam logic [15:0] ADDR_MSIP     = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO   = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI   = 16'h4004;
    localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        accept_s;
    logic        wr_s;
    logic [15:0] addr_word_s;
    logic [1:0]  addr_unused_s;
    logic        hit_s;
    logic [31:0] rd_mux_s;

    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [15:0] pre_q, pre_d;
    logic        tick_s;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        xtip_q, xsip_q;

    assign addr_word_s   = {bus.addr[15:2], 2'b00};
    assign addr_unused_s = bus.addr[1:0];
    assign wr_s          = accept_s && bus.we;

    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    accept_s = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux sees pre-edge register values, so reads never observe a same-edge write or tick.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        hit_s    = 1'b1;
        case (addr_word_s)
            ADDR_MSIP:     rd_mux_s = {31'h0000_0000, msip_q};
            ADDR_CMP_LO:   rd_mux_s = mtimecmp_q[31:0];
            ADDR_CMP_HI:   rd_mux_s = mtimecmp_q[63:32];
            ADDR_MTIME_LO: rd_mux_s = mtime_q[31:0];
            ADDR_MTIME_HI: rd_mux_s = mtime_q[63:32];
            default: begin
                rd_mux_s = 32'h0000_0000;
                hit_s    = 1'b0;
            end
        endcase
    end

    always_comb begin
        ack_d   = accept_s;
        err_d   = accept_s && BASE_CHECK && !hit_s;
        if (accept_s) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    always_comb begin
        tick_s = 1'b0;
        pre_d  = pre_q;
        if (halt_i) begin
            pre_d = pre_q;
        end else if (pre_q >= PRE_MAX) begin
            tick_s = 1'b1;
            pre_d  = 16'h0000;
        end else begin
            pre_d  = pre_q + 16'd1;
        end
    end

    // A bus write to either mtime half swallows the tick of that edge.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_s && (addr_word_s == ADDR_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], bus.wdata};
        end else if (wr_s && (addr_word_s == ADDR_MTIME_HI)) begin
            mtime_d = {bus.wdata, mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        if (wr_s && (addr_word_s == ADDR_CMP_LO)) begin
            mtimecmp_d = {mtimecmp_q[63:32], bus.wdata};
        end else if (wr_s && (addr_word_s == ADDR_CMP_HI)) begin
            mtimecmp_d = {bus.wdata, mtimecmp_q[31:0]};
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (wr_s && (addr_word_s == ADDR_MSIP)) begin
            msip_d = bus.wdata[0];
        end else begin
            msip_d = msip_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            pre_q      <= 16'h0000;
            mtime_q    <= 64'h0000_0000_0000_0000;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            xtip_q     <= 1'b0;
            xsip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            pre_q      <= pre_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            xtip_q     <= (mtime_q >= mtimecmp_q);
            xsip_q     <= msip_q;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign xtip_o    = xtip_q;
    assign xsip_o    = xsip_q;
    assign mtime_o   = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance at PRESCALE=1 for bus/compare work,
// one at PRESCALE=4 for halt and prescaler phase behaviour.
module tb_clint_timer;

    logic        clk;
    logic        rst_n;
    logic        halt1;
    logic        halt4;
    logic        xtip1, xsip1, xtip4, xsip4;
    logic [63:0] mtime1, mtime4;

    int n_cmp  = 0;
    int n_fail = 0;

    clint_timer_if bus1 ();
    clint_timer_if bus4 ();

    clint_timer #(.PRESCALE(1), .BASE_CHECK(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .halt_i(halt1),
        .xtip_o(xtip1), .xsip_o(xsip1), .mtime_o(mtime1)
    );

    clint_timer #(.PRESCALE(4), .BASE_CHECK(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .halt_i(halt4),
        .xtip_o(xtip4), .xsip_o(xsip4), .mtime_o(mtime4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        bus1.req   = 1'b1;
        bus1.we    = we;
        bus1.addr  = addr;
        bus1.wdata = wdata;
        @(posedge clk); #1;
        bus1.req   = 1'b0;
        chk("ack_rise", 64'(bus1.ack), 64'd1);
        rdata = bus1.rdata;
        err   = bus1.err;
        @(posedge clk); #1;
        chk("ack_fall", 64'(bus1.ack), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [63:0] m0;
        logic        seen;

        rst_n      = 1'b0;
        halt1      = 1'b0;
        halt4      = 1'b0;
        bus1.req   = 1'b0;
        bus1.we    = 1'b0;
        bus1.addr  = 16'h0000;
        bus1.wdata = 32'h0000_0000;
        bus4.req   = 1'b0;
        bus4.we    = 1'b0;
        bus4.addr  = 16'h0000;
        bus4.wdata = 32'h0000_0000;

        #2;
        chk("rst_ack",   64'(bus1.ack),   64'd0);
        chk("rst_err",   64'(bus1.err),   64'd0);
        chk("rst_rdata", 64'(bus1.rdata), 64'd0);
        chk("rst_mtime", mtime1,          64'd0);
        chk("rst_xtip",  64'(xtip1),      64'd0);
        #20;
        rst_n = 1'b1;

        // 1: ten ticks after reset, then read mtimecmp high
        repeat (10) @(posedge clk);
        #1;
        chk("t1_mtime10", mtime1, 64'd10);
        chk("t1_xtip", 64'(xtip1), 64'd0);
        chk("t1_xsip", 64'(xsip1), 64'd0);
        xfer(1'b0, 16'h4004, 32'h0, rd, er);
        chk("t1_cmp_hi", 64'(rd), 64'h0000_0000_FFFF_FFFF);
        chk("t1_err", 64'(er), 64'd0);

        // 2: compare at 0x20
        xfer(1'b1, 16'hBFF8, 32'h0000_0000, rd, er);
        chk("t2_mtime_loaded", mtime1, 64'd1);
        xfer(1'b1, 16'h4000, 32'h0000_0020, rd, er);
        xfer(1'b1, 16'h4004, 32'h0000_0000, rd, er);
        chk("t2_xtip_before", 64'(xtip1), 64'd0);
        for (int i = 0; i < 64 && mtime1 != 64'h20; i++) begin
            @(posedge clk); #1;
        end
        chk("t2_reach_20", mtime1, 64'h20);
        chk("t2_xtip_lag", 64'(xtip1), 64'd0);
        @(posedge clk); #1;
        chk("t2_xtip_rise", 64'(xtip1), 64'd1);
        bus1.req   = 1'b1;
        bus1.we    = 1'b1;
        bus1.addr  = 16'h4004;
        bus1.wdata = 32'h0000_0001;
        @(posedge clk); #1;
        bus1.req = 1'b0;
        chk("t2_xtip_hold", 64'(xtip1), 64'd1);
        @(posedge clk); #1;
        chk("t2_xtip_fall", 64'(xtip1), 64'd0);

        // 3: carry from lo into hi, and full wrap
        xfer(1'b1, 16'hBFFC, 32'h0000_0000, rd, er);
        xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, er);
        chk("t3_carry", mtime1, 64'h0000_0001_0000_0000);
        @(posedge clk); #1;
        chk("t3_carry_next", mtime1, 64'h0000_0001_0000_0001);
        xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd, er);
        xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, er);
        chk("t3_wrap", mtime1, 64'h0);

        // 4: PRESCALE=4 halt mid-count
        m0   = mtime4;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (mtime4 != m0) seen = 1'b1;
        end
        chk("t4_tick_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0    = mtime4;
        halt4 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_halt_mid", mtime4, m0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_halt_end", mtime4, m0);
        halt4 = 1'b0;
        @(posedge clk); #1;
        chk("t4_resume_1", mtime4, m0);
        @(posedge clk); #1;
        chk("t4_resume_2", mtime4, m0 + 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_resume_5", mtime4, m0 + 64'd1);
        @(posedge clk); #1;
        chk("t4_resume_6", mtime4, m0 + 64'd2);

        // 5: software interrupt
        xfer(1'b1, 16'h0000, 32'hFFFF_FFFF, rd, er);
        chk("t5_xsip_set", 64'(xsip1), 64'd1);
        xfer(1'b0, 16'h0000, 32'h0, rd, er);
        chk("t5_msip_read", 64'(rd), 64'd1);
        xfer(1'b1, 16'h0000, 32'h0000_0000, rd, er);
        chk("t5_xsip_clr", 64'(xsip1), 64'd0);

        // 6: unmapped read, req during RESP, reset during RESP
        xfer(1'b0, 16'h1234, 32'h0, rd, er);
        chk("t6_unmapped_rdata", 64'(rd), 64'd0);
        chk("t6_unmapped_err", 64'(er), 64'd1);
        bus1.req  = 1'b1;
        bus1.we   = 1'b0;
        bus1.addr = 16'h0000;
        @(posedge clk); #1;
        chk("t6_busy_ack", 64'(bus1.ack), 64'd1);
        @(posedge clk); #1;
        bus1.req = 1'b0;
        chk("t6_busy_ignored", 64'(bus1.ack), 64'd0);
        @(posedge clk); #1;
        chk("t6_single_ack", 64'(bus1.ack), 64'd0);

        xfer(1'b1, 16'h0000, 32'h0000_0001, rd, er);
        bus1.req  = 1'b1;
        bus1.we   = 1'b0;
        bus1.addr = 16'h4000;
        @(posedge clk); #1;
        bus1.req = 1'b0;
        chk("t6_pre_rst_ack", 64'(bus1.ack), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", 64'(bus1.ack), 64'd0);
        chk("t6_rst_rdata", 64'(bus1.rdata), 64'd0);
        chk("t6_rst_mtime", mtime1, 64'd0);
        chk("t6_rst_xsip", 64'(xsip1), 64'd0);
        chk("t6_rst_xtip", 64'(xtip1), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 16'h4000, 32'h0, rd, er);
        chk("t6_rst_cmp_lo", 64'(rd), 64'h0000_0000_FFFF_FFFF);
        xfer(1'b0, 16'h0000, 32'h0, rd, er);
        chk("t6_rst_msip", 64'(rd), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
